adc_128s022_ctrl: RTL and testbench

SPI master for the on-board ADC128S022 8-channel 12-bit converter. It sits directly upstream of the ADC: it drives ADC_CS_N, ADC_SCLK and ADC_SADDR, and captures ADC_SDAT. Each 16-bit frame returns one 12-bit result tagged with its channel. It supports single-shot conversions on request and continuous round-robin scanning of channels 0..7.

---
 rtl/adc_ctrl_pkg.sv | 27 ++
 rtl/adc_128s022_ctrl_tick.sv | 35 +++
 rtl/adc_128s022_ctrl.sv | 178 +++++++++++++++++
 tb/tb_adc_128s022_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC128S022 SPI controller.
// Frame layout: 16 SCLK periods, address in bits 13..11, data in the last 12.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SCLK_LO,
    SCLK_HI,
    CS_HOLD
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int ADDR_LSB   = 11;
  localparam int CH_BITS    = 3;

  function automatic logic [FRAME_BITS-1:0] mk_cmd(
    input logic [CH_BITS-1:0] ch
  );
    logic [FRAME_BITS-1:0] c;
    c = '0;
    c[ADDR_LSB +: CH_BITS] = ch;
    return c;
  endfunction

endpackage

// File: rtl/adc_128s022_ctrl_tick.sv
// adc_tick_gen: free-running divider, one-cycle tick every CLK_DIV clocks.
// Held at zero while disabled or cleared.
module adc_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick = en && (div_cnt_q == TERM);

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (clr || !en || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/adc_128s022_ctrl.sv
// adc_128s022_ctrl: SPI master for the ADC128S022 8-channel 12-bit ADC.
// Single-shot or round-robin scan; one tagged 12-bit result per frame.
module adc_128s022_ctrl #(
  parameter int CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  channel,
  input  logic        scan_en,
  output logic        busy,
  output logic        data_valid,
  output logic [11:0] data,
  output logic [2:0]  data_ch,
  output logic        ADC_CS_N,
  output logic        ADC_SCLK,
  output logic        ADC_SADDR,
  input  logic        ADC_SDAT
);

  import adc_ctrl_pkg::*;

  localparam int BCW = $clog2(FRAME_BITS);
  localparam logic [BCW-1:0] LAST = BCW'(FRAME_BITS - 1);

  state_e state_q, state_d;

  logic [CH_BITS-1:0]    frm_ch_q, frm_ch_d;
  logic [CH_BITS-1:0]    adc_ch_q, adc_ch_d;
  logic [CH_BITS-1:0]    scan_ch_q, scan_ch_d;
  logic [CH_BITS-1:0]    data_ch_q, data_ch_d;
  logic [CH_BITS-1:0]    req_ch;
  logic [FRAME_BITS-1:0] cmd_q, cmd_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [DATA_BITS-1:0]  sh_q, sh_d;
  logic [DATA_BITS-1:0]  data_q, data_d;

  logic busy_q, busy_d;
  logic dv_q, dv_d;
  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic saddr_q, saddr_d;
  logic launch, tick, div_en;

  assign div_en  = (state_q != IDLE);
  assign bit_nxt = bit_cnt_q + 1'b1;

  adc_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (reset),
    .en  (div_en),
    .clr (launch),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    frm_ch_d  = frm_ch_q;
    adc_ch_d  = adc_ch_q;
    scan_ch_d = scan_ch_q;
    data_ch_d = data_ch_q;
    cmd_d     = cmd_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    busy_d    = busy_q;
    dv_d      = 1'b0;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    saddr_d   = saddr_q;
    launch    = 1'b0;
    req_ch    = scan_en ? scan_ch_q : channel;

    unique case (state_q)
      IDLE: begin
        if (scan_en || start) begin
          launch   = 1'b1;
          frm_ch_d = req_ch;
          cmd_d    = mk_cmd(req_ch);
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          state_d  = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b0;
          saddr_d = cmd_q[LAST - bit_cnt_q];
          state_d = SCLK_LO;
        end
      end
      SCLK_LO: begin
        if (tick) begin
          sclk_d  = 1'b1;
          sh_d    = {sh_q[DATA_BITS-2:0], ADC_SDAT};
          state_d = SCLK_HI;
        end
      end
      SCLK_HI: begin
        if (tick) begin
          if (bit_cnt_q == LAST) begin
            cs_n_d  = 1'b1;
            saddr_d = 1'b0;
            state_d = CS_HOLD;
          end else begin
            bit_cnt_d = bit_nxt;
            sclk_d    = 1'b0;
            saddr_d   = cmd_q[LAST - bit_nxt];
            state_d   = SCLK_LO;
          end
        end
      end
      CS_HOLD: begin
        if (tick) begin
          // ADC returns the channel addressed in the previous frame
          data_d    = sh_q;
          data_ch_d = adc_ch_q;
          adc_ch_d  = frm_ch_q;
          dv_d      = 1'b1;
          busy_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = IDLE;
          if (scan_en) begin
            scan_ch_d = frm_ch_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      frm_ch_q  <= '0;
      adc_ch_q  <= '0;
      scan_ch_q <= '0;
      data_ch_q <= '0;
      cmd_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      saddr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frm_ch_q  <= frm_ch_d;
      adc_ch_q  <= adc_ch_d;
      scan_ch_q <= scan_ch_d;
      data_ch_q <= data_ch_d;
      cmd_q     <= cmd_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      saddr_q   <= saddr_d;
    end
  end

  assign busy       = busy_q;
  assign data_valid = dv_q;
  assign data       = data_q;
  assign data_ch    = data_ch_q;
  assign ADC_CS_N   = cs_n_q;
  assign ADC_SCLK   = sclk_q;
  assign ADC_SADDR  = saddr_q;

endmodule

// File: tb/tb_adc_128s022_ctrl.sv
// Bench for adc_128s022_ctrl: pin-level ADC128S022 model plus a
// frame-level expectation model (result = channel requested one frame earlier).
module tb_adc_128s022_ctrl;

  localparam int CLK_DIV   = 16;
  localparam int FRAME_CYC = 34 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  channel;
  logic        scan_en;
  logic        busy;
  logic        data_valid;
  logic [11:0] data;
  logic [2:0]  data_ch;
  logic        ADC_CS_N;
  logic        ADC_SCLK;
  logic        ADC_SADDR;
  logic        ADC_SDAT = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  adc_128s022_ctrl #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .channel   (channel),
    .scan_en   (scan_en),
    .busy      (busy),
    .data_valid(data_valid),
    .data      (data),
    .data_ch   (data_ch),
    .ADC_CS_N  (ADC_CS_N),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_SADDR (ADC_SADDR),
    .ADC_SDAT  (ADC_SDAT)
  );

  always #5 clk = ~clk;

  // ADC device model: converts the address latched in the previous full frame
  logic [11:0] mem [8];
  logic [2:0]  adc_addr = 3'd0;
  logic [11:0] cur_val = '0;
  logic [15:0] din_sr = '0;
  logic [15:0] last_din = '0;
  logic [3:0]  bi;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b1;
  int fall_cnt = 0, rise_cnt = 0, last_pulses = 0, frames_done = 0;
  int cyc = 0, t_rise = 0, gap_cyc = 0, sclk_toggles = 0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (reset) adc_addr = 3'd0;
    if (cs_prev && !ADC_CS_N) begin
      fall_cnt = 0;
      rise_cnt = 0;
      din_sr   = '0;
      cur_val  = mem[adc_addr];
      gap_cyc  = cyc - t_rise;
    end
    if (!cs_prev && ADC_CS_N) begin
      t_rise = cyc;
      if (!reset && rise_cnt == 16) begin
        adc_addr    = din_sr[13:11];
        last_din    = din_sr;
        last_pulses = fall_cnt;
        frames_done++;
      end
    end
    if (ADC_SCLK !== sclk_prev) sclk_toggles++;
    if (!ADC_CS_N && sclk_prev && !ADC_SCLK) begin
      fall_cnt++;
      if (fall_cnt > 4 && fall_cnt <= 16) begin
        bi = 4'(16 - fall_cnt);
        ADC_SDAT = cur_val[bi];
      end else begin
        ADC_SDAT = 1'b0;
      end
    end
    if (!ADC_CS_N && !sclk_prev && ADC_SCLK) begin
      rise_cnt++;
      din_sr = {din_sr[14:0], ADC_SADDR};
    end
    cs_prev   = ADC_CS_N;
    sclk_prev = ADC_SCLK;
  end

  logic [2:0] exp_prev;

  task automatic apply_reset();
    reset   = 1'b1;
    start   = 1'b0;
    scan_en = 1'b0;
    channel = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    exp_prev = 3'd0;
  endtask

  task automatic test_reset();
    int t0, bad;
    reset = 1'b1;
    start = 1'b0;
    scan_en = 1'b0;
    channel = 3'd0;
    #1;
    n_checks++;
    if (ADC_CS_N !== 1'b1 || ADC_SCLK !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pins: cs_n=%b sclk=%b busy=%b want 1 1 0",
               ADC_CS_N, ADC_SCLK, busy);
    end
    apply_reset();
    t0  = sclk_toggles;
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (ADC_CS_N !== 1'b1 || ADC_SCLK !== 1'b1 || ADC_SADDR !== 1'b0 ||
          busy !== 1'b0 || data_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_pins: %0d bad cycles, want 0", bad);
    end
    n_checks++;
    if (data !== 12'h000 || data_ch !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_data: data=%h ch=%0d want 000 0", data, data_ch);
    end
    n_checks++;
    if (sclk_toggles != t0) begin
      n_fail++;
      $display("FAIL idle_sclk: %0d toggles, want 0", sclk_toggles - t0);
    end
  endtask

  task automatic run_single(input logic [2:0] ch, input string tag);
    int lat;
    logic [2:0]  e_ch;
    logic [11:0] e_data;
    e_ch   = exp_prev;
    e_data = mem[exp_prev];
    @(negedge clk);
    start   = 1'b1;
    channel = ch;
    @(posedge clk); #1;
    start   = 1'b0;
    channel = 3'($urandom);
    n_checks++;
    if (busy !== 1'b1 || ADC_CS_N !== 1'b0) begin
      n_fail++;
      $display("FAIL %s launch: busy=%b cs_n=%b want 1 0", tag, busy, ADC_CS_N);
    end
    lat = 0;
    while (data_valid !== 1'b1 && lat < 2 * FRAME_CYC) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != FRAME_CYC) begin
      n_fail++;
      $display("FAIL %s latency: %0d want %0d", tag, lat, FRAME_CYC);
    end
    n_checks++;
    if (data !== e_data || data_ch !== e_ch) begin
      n_fail++;
      $display("FAIL %s result: data=%h ch=%0d want %h %0d",
               tag, data, data_ch, e_data, e_ch);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_end: busy=%b want 0", tag, busy);
    end
    n_checks++;
    if (last_pulses != 16 || last_din !== {2'b00, ch, 11'd0}) begin
      n_fail++;
      $display("FAIL %s frame: pulses=%0d din=%h want 16 %h",
               tag, last_pulses, last_din, {2'b00, ch, 11'd0});
    end
    @(posedge clk); #1;
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s strobe: data_valid=%b want 0", tag, data_valid);
    end
    exp_prev = ch;
  endtask

  task automatic test_single_shot();
    mem[0] = 12'h5A3;
    mem[5] = 12'hFFF;
    mem[2] = 12'($urandom);
    run_single(3'd5, "single_a");
    run_single(3'd2, "single_b");
    run_single(3'($urandom), "single_c");
  endtask

  task automatic test_random_single();
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 8; k++) mem[k] = 12'($urandom);
      run_single(3'($urandom), "random");
    end
  endtask

  task automatic test_busy_ignore();
    int dv_cnt, f0;
    logic [2:0]  ch_a, ch_b, got_ch, e_ch;
    logic [11:0] got, e_data;
    ch_a   = 3'($urandom);
    ch_b   = ch_a + 3'd3;
    e_ch   = exp_prev;
    e_data = mem[exp_prev];
    got    = '0;
    got_ch = '0;
    f0     = frames_done;
    @(negedge clk);
    start   = 1'b1;
    channel = ch_a;
    @(negedge clk);
    start = 1'b0;
    repeat (98) @(negedge clk);
    start   = 1'b1;
    channel = ch_b;
    @(negedge clk);
    start = 1'b0;
    dv_cnt = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      @(posedge clk); #1;
      if (data_valid === 1'b1) begin
        dv_cnt++;
        if (dv_cnt == 1) begin
          got    = data;
          got_ch = data_ch;
        end
      end
    end
    n_checks++;
    if (dv_cnt != 1 || frames_done - f0 != 1) begin
      n_fail++;
      $display("FAIL busy_ignore count: dv=%0d frames=%0d want 1 1",
               dv_cnt, frames_done - f0);
    end
    n_checks++;
    if (got !== e_data || got_ch !== e_ch || last_din !== {2'b00, ch_a, 11'd0}) begin
      n_fail++;
      $display("FAIL busy_ignore result: data=%h ch=%0d din=%h want %h %0d %h",
               got, got_ch, last_din, e_data, e_ch, {2'b00, ch_a, 11'd0});
    end
    exp_prev = ch_a;
  endtask

  task automatic test_scan();
    int lat, quiet;
    logic [2:0]  exp_scan, e_ch;
    logic [11:0] e_data;
    apply_reset();
    for (int k = 0; k < 8; k++) mem[k] = 12'(k * 257);
    exp_scan = 3'd0;
    @(negedge clk);
    scan_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e_ch   = exp_prev;
      e_data = mem[e_ch];
      lat    = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (i == 9 && lat == 50) scan_en = 1'b0;
      end while (data_valid !== 1'b1 && lat < 2 * FRAME_CYC);
      n_checks++;
      if (lat != FRAME_CYC + 1) begin
        n_fail++;
        $display("FAIL scan%0d latency: %0d want %0d", i, lat, FRAME_CYC + 1);
      end
      n_checks++;
      if (data !== e_data || data_ch !== e_ch) begin
        n_fail++;
        $display("FAIL scan%0d result: data=%h ch=%0d want %h %0d",
                 i, data, data_ch, e_data, e_ch);
      end
      n_checks++;
      if (last_din !== {2'b00, exp_scan, 11'd0}) begin
        n_fail++;
        $display("FAIL scan%0d addr: din=%h want %h",
                 i, last_din, {2'b00, exp_scan, 11'd0});
      end
      if (i > 0) begin
        n_checks++;
        if (gap_cyc != CLK_DIV + 1) begin
          n_fail++;
          $display("FAIL scan%0d cs_gap: %0d want %0d", i, gap_cyc, CLK_DIV + 1);
        end
      end
      exp_prev = exp_scan;
      exp_scan = exp_scan + 3'd1;
    end
    quiet = 0;
    repeat (4 * CLK_DIV) begin
      @(posedge clk); #1;
      if (ADC_CS_N !== 1'b1 || busy !== 1'b0) quiet++;
    end
    n_checks++;
    if (quiet != 0) begin
      n_fail++;
      $display("FAIL scan_stop: %0d active cycles after scan_en low, want 0", quiet);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    @(negedge clk);
    start   = 1'b1;
    channel = 3'(1 + $urandom_range(6));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #3;
      n++;
    end while (fall_cnt < 8 && n < FRAME_CYC);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (n >= FRAME_CYC || ADC_CS_N !== 1'b1 || ADC_SCLK !== 1'b1 ||
        busy !== 1'b0 || ADC_SADDR !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: wait=%0d cs_n=%b sclk=%b busy=%b saddr=%b want <%0d 1 1 0 0",
               n, ADC_CS_N, ADC_SCLK, busy, ADC_SADDR, FRAME_CYC);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    exp_prev = 3'd0;
    for (int k = 0; k < 8; k++) mem[k] = 12'($urandom);
    run_single(3'($urandom), "after_reset");
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = 12'($urandom);
    test_reset();
    test_single_shot();
    test_random_single();
    test_busy_ignore();
    test_scan();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
